// File: rtl/mem_access_ctrl_pkg.sv
// Shared widths, size codes, FSM encoding and latched bus-op payload for the MEM-stage data-bus initiator.
package mem_access_ctrl_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned SIZE_W = 2;

    typedef enum logic [SIZE_W-1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_DATA,
        ST_DONE,
        ST_DISCARD
    } state_e;

    typedef struct packed {
        logic               wr;
        size_e              size;
        logic [SEL_W-1:0]   wstrb;
        logic [DATA_W-1:0]  wdata;
    } bus_op_t;

endpackage

// File: rtl/mem_lane_gen.sv
// Combinational lane generator: access size, byte strobes, replicated store data and aligned address.
module mem_lane_gen
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [SEL_W-1:0]   mem_sel,
    input  logic [ADDR_W-1:0]  address,
    input  logic [DATA_W-1:0]  write_data,
    output size_e              size,
    output logic [SEL_W-1:0]   strobe,
    output logic [DATA_W-1:0]  lane_data,
    output logic [ADDR_W-1:0]  aligned_addr
);

    // Unrecognised mem_sel patterns fall back to a word access.
    always_comb begin
        size         = SIZE_WORD;
        strobe       = {SEL_W{1'b1}};
        lane_data    = write_data;
        aligned_addr = {address[ADDR_W-1:2], 2'b00};
        case (mem_sel)
            4'b0001: begin
                size         = SIZE_BYTE;
                strobe       = 4'b0001 << address[1:0];
                lane_data    = {4{write_data[7:0]}};
                aligned_addr = address;
            end
            4'b0011: begin
                size         = SIZE_HALF;
                strobe       = 4'b0011 << {address[1], 1'b0};
                lane_data    = {2{write_data[15:0]}};
                aligned_addr = {address[ADDR_W-1:1], 1'b0};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-bus initiator: single-outstanding req/addr_ok/data_ok transaction with pipeline stall.
// Define MEM_ALIGN_CHECK_EN to reject misaligned half/word accesses via addr_error instead of aligning them.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mem_read_flag,
    input  logic               mem_write_flag,
    input  logic [SEL_W-1:0]   mem_sel,
    input  logic [ADDR_W-1:0]  address,
    input  logic [DATA_W-1:0]  write_data,
    input  logic               advance,
    input  logic               flush,
    output logic               stall_req,
    output logic [DATA_W-1:0]  ram_read_data,
    output logic               data_req,
    output logic               data_wr,
    output logic [SIZE_W-1:0]  data_size,
    output logic [ADDR_W-1:0]  data_addr,
    output logic [SEL_W-1:0]   data_wstrb,
    output logic [DATA_W-1:0]  data_wdata,
    input  logic               data_addr_ok,
    input  logic               data_data_ok,
    input  logic [DATA_W-1:0]  data_rdata,
    output logic               bus_error,
    output logic               addr_error
);

    localparam int unsigned CNT_W = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT);

    state_e              state_q, state_d;
    bus_op_t             op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   ram_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                bus_err_q;

    size_e               lg_size;
    logic [SEL_W-1:0]    lg_strobe;
    logic [DATA_W-1:0]   lg_data;
    logic [ADDR_W-1:0]   lg_addr;

    logic new_op, align_fault, issue, expire;
    logic load_op, capture, timeout;

    mem_lane_gen #(.ADDR_W(ADDR_W)) u_lane_gen (
        .mem_sel      (mem_sel),
        .address      (address),
        .write_data   (write_data),
        .size         (lg_size),
        .strobe       (lg_strobe),
        .lane_data    (lg_data),
        .aligned_addr (lg_addr)
    );

    assign new_op = (mem_read_flag | mem_write_flag) & ~flush;

`ifdef MEM_ALIGN_CHECK_EN
    assign align_fault = ((lg_size == SIZE_HALF) & address[0]) |
                         ((lg_size == SIZE_WORD) & (|address[1:0]));
`else
    assign align_fault = 1'b0;
`endif

    assign issue      = new_op & ~align_fault;
    assign addr_error = (state_q == ST_IDLE) & new_op & align_fault;
    assign expire     = (BUS_TIMEOUT != 0) && (cnt_q == CNT_W'(BUS_TIMEOUT - 1));

    // Next state and stall; a flush after acceptance must still drain the bus response.
    always_comb begin
        state_d   = state_q;
        stall_req = 1'b0;
        load_op   = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    state_d   = ST_REQ;
                    load_op   = 1'b1;
                    stall_req = 1'b1;
                end
            end
            ST_REQ: begin
                stall_req = 1'b1;
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        if (flush) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DONE;
                            capture = 1'b1;
                        end
                    end else begin
                        state_d = flush ? ST_DISCARD : ST_WAIT_DATA;
                    end
                end else if (flush) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_DATA: begin
                stall_req = 1'b1;
                if (data_data_ok) begin
                    if (flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                        capture = 1'b1;
                    end
                end else if (flush) begin
                    state_d = ST_DISCARD;
                end else if (expire) begin
                    state_d = ST_IDLE;
                    timeout = 1'b1;
                end
            end
            ST_DISCARD: begin
                stall_req = 1'b1;
                if (data_data_ok) begin
                    state_d = ST_IDLE;
                end else if (expire) begin
                    state_d = ST_IDLE;
                    timeout = 1'b1;
                end
            end
            ST_DONE: begin
                if (advance | flush) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            ram_q     <= '0;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bus_err_q <= timeout;
            if (load_op) begin
                op_q <= '{wr:    mem_write_flag,
                          size:  lg_size,
                          wstrb: mem_write_flag ? lg_strobe : {SEL_W{1'b0}},
                          wdata: mem_write_flag ? lg_data : {DATA_W{1'b0}}};
                addr_q <= lg_addr;
            end
            if (capture && !op_q.wr) begin
                ram_q <= data_rdata;
            end
            // Watchdog restarts on every entry into a data-wait state.
            if ((state_d != state_q) && ((state_d == ST_WAIT_DATA) || (state_d == ST_DISCARD))) begin
                cnt_q <= '0;
            end else if ((state_q == ST_WAIT_DATA) || (state_q == ST_DISCARD)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign data_req      = (state_q == ST_REQ);
    assign data_wr       = op_q.wr;
    assign data_size     = op_q.size;
    assign data_addr     = addr_q;
    assign data_wstrb    = op_q.wstrb;
    assign data_wdata    = op_q.wdata;
    assign ram_read_data = ram_q;
    assign bus_error     = bus_err_q;

endmodule
